calc_issue_ctrl: RTL and testbench

- Initiator/sequencer for the team's 2-bit four-function calculator datapath. That datapath is combinational, with operands op1/op2, one-hot select {add,mult,sub,div} and a 4-bit ans.
- This block accepts encoded requests over a valid/ready handshake and drives operands plus the one-hot select to the calculator.
- It waits a settle interval, captures ans, and returns a tagged response over a second valid/ready handshake.
- It sits between a command source (keypad/host FSM) and the calculator datapath.

---
 rtl/calc_pkg.sv | 18 +
 rtl/calc_issue_ctrl_if.sv | 30 +++
 rtl/calc_op_decode.sv | 15 +
 rtl/calc_issue_ctrl.sv | 97 +++++++++
 tb/tb_calc_issue_ctrl.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// calc_pkg: shared opcodes, FSM states, select encodings and request record for calc_issue_ctrl.
package calc_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, DRIVE, RESPOND} state_e;
  // one-hot selects ordered {add,mult,sub,div}
  localparam logic [3:0] SEL_ADD = 4'b1000;
  localparam logic [3:0] SEL_MUL = 4'b0100;
  localparam logic [3:0] SEL_SUB = 4'b0010;
  localparam logic [3:0] SEL_DIV = 4'b0001;
  typedef struct packed {
    op_e        op;
    logic [1:0] a;
    logic [1:0] b;
  } req_t;
  function automatic logic is_div0(input logic [1:0] op, input logic [1:0] b);
    return op == OP_DIV && b == 2'b00;
  endfunction
endpackage

// File: rtl/calc_issue_ctrl_if.sv
// calc_issue_ctrl_if: request, response and calculator-datapath signals of the issue controller.
interface calc_issue_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [1:0] req_a;
  logic [1:0] req_b;
  logic [1:0] calc_op1;
  logic [1:0] calc_op2;
  logic       calc_add;
  logic       calc_sub;
  logic       calc_mult;
  logic       calc_div;
  logic [3:0] calc_ans;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       rsp_neg;
  modport master (
    input  req_valid, req_op, req_a, req_b, calc_ans, rsp_ready,
    output req_ready, calc_op1, calc_op2, calc_add, calc_sub, calc_mult, calc_div,
           rsp_valid, rsp_data, rsp_err, rsp_neg
  );
  modport slave (
    output req_valid, req_op, req_a, req_b, calc_ans, rsp_ready,
    input  req_ready, calc_op1, calc_op2, calc_add, calc_sub, calc_mult, calc_div,
           rsp_valid, rsp_data, rsp_err, rsp_neg
  );
endinterface

// File: rtl/calc_op_decode.sv
// calc_op_decode: opcode to one-hot {add,mult,sub,div} select, all zero when disabled.
module calc_op_decode
  import calc_pkg::*;
(
  input  op_e        op_i,
  input  logic       en_i,
  output logic [3:0] sel_o
);
  always_comb begin
    sel_o = !en_i            ? 4'b0000 :
            op_i == OP_ADD   ? SEL_ADD :
            op_i == OP_SUB   ? SEL_SUB :
            op_i == OP_MUL   ? SEL_MUL : SEL_DIV;
  end
endmodule

// File: rtl/calc_issue_ctrl.sv
// calc_issue_ctrl: accepts calculator requests, drives the datapath for a settle interval, returns the captured result.
module calc_issue_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  calc_issue_ctrl_if.master  bus,
  output logic [CNT_W-1:0]   op_count
);
  localparam int unsigned SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  state_e           state_q, state_d;
  req_t             req_q, req_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [3:0]       data_q, data_d;
  logic             err_q, err_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drive;
  logic [3:0]       sel;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      neg_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      neg_q   <= neg_d;
      count_q <= count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    neg_d   = neg_q;
    count_d = count_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        req_d = '{op: op_e'(bus.req_op), a: bus.req_a, b: bus.req_b};
        cnt_d = '0;
        // divide-by-zero never reaches the datapath
        if (is_div0(bus.req_op, bus.req_b)) begin
          state_d = RESPOND;
          data_d  = 4'b0000;
          err_d   = 1'b1;
          neg_d   = 1'b0;
        end else begin
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          state_d = RESPOND;
          data_d  = bus.calc_ans;
          err_d   = 1'b0;
          neg_d   = req_q.op == OP_SUB && bus.calc_ans[2];
        end
      end
      RESPOND: if (bus.rsp_ready) begin
        state_d = IDLE;
        count_d = count_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  calc_op_decode u_dec (
    .op_i  (req_q.op),
    .en_i  (drive),
    .sel_o (sel)
  );
  always_comb begin
    drive         = state_q == DRIVE;
    bus.req_ready = state_q == IDLE;
    bus.rsp_valid = state_q == RESPOND;
    bus.calc_op1  = drive ? req_q.a : 2'b00;
    bus.calc_op2  = drive ? req_q.b : 2'b00;
    {bus.calc_add, bus.calc_mult, bus.calc_sub, bus.calc_div} = sel;
    bus.rsp_data  = data_q;
    bus.rsp_err   = err_q;
    bus.rsp_neg   = neg_q;
    op_count      = count_q;
  end
endmodule

// File: tb/tb_calc_issue_ctrl.sv
// tb_calc_issue_ctrl: directed checks of calc_issue_ctrl with SETTLE_CYCLES=1 and SETTLE_CYCLES=3.
module tb_calc_issue_ctrl;
  logic clk = 1'b0;
  logic rst, rst3;
  logic [7:0] cnt1, cnt3;
  logic ovr;
  logic [3:0] ovr_val;
  int n_cmp = 0;
  int n_err = 0;
  calc_issue_ctrl_if i1 ();
  calc_issue_ctrl_if i3 ();
  calc_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(i1), .op_count(cnt1));
  calc_issue_ctrl #(.SETTLE_CYCLES(3), .CNT_W(8)) dut3 (.clk(clk), .rst(rst3), .bus(i3), .op_count(cnt3));
  always #5 clk = ~clk;
  // behavioural model of the combinational calculator datapath
  function automatic logic [3:0] calc(input logic a_, s_, m_, d_, input logic [1:0] x, y);
    logic [2:0] df;
    df = {1'b0, x} - {1'b0, y};
    return a_ ? {2'b0, x} + {2'b0, y} :
           s_ ? {1'b0, df} :
           m_ ? {2'b0, x} * {2'b0, y} :
           (d_ && y != 2'b00) ? {x % y, x / y} : 4'b0000;
  endfunction
  always_comb i1.calc_ans = ovr ? ovr_val : calc(i1.calc_add, i1.calc_sub, i1.calc_mult, i1.calc_div, i1.calc_op1, i1.calc_op2);
  always_comb i3.calc_ans = calc(i3.calc_add, i3.calc_sub, i3.calc_mult, i3.calc_div, i3.calc_op1, i3.calc_op2);
  function automatic logic [3:0] sel1();
    return {i1.calc_add, i1.calc_mult, i1.calc_sub, i1.calc_div};
  endfunction
  function automatic logic [3:0] sel3();
    return {i3.calc_add, i3.calc_mult, i3.calc_sub, i3.calc_div};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic req1(input logic [1:0] op, a, b);
    i1.req_valid = 1'b1;
    i1.req_op = op;
    i1.req_a = a;
    i1.req_b = b;
  endtask
  task automatic req3(input logic [1:0] op, a, b);
    i3.req_valid = 1'b1;
    i3.req_op = op;
    i3.req_a = a;
    i3.req_b = b;
  endtask
  task automatic nxt();
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; rst3 = 1'b1; ovr = 1'b0; ovr_val = 4'h0;
    i1.req_valid = 0; i1.req_op = 0; i1.req_a = 0; i1.req_b = 0; i1.rsp_ready = 0;
    i3.req_valid = 0; i3.req_op = 0; i3.req_a = 0; i3.req_b = 0; i3.rsp_ready = 0;
    repeat (2) nxt();
    chk("rst_ready", 32'(i1.req_ready), 1);
    chk("rst_valid", 32'(i1.rsp_valid), 0);
    chk("rst_data", 32'(i1.rsp_data), 0);
    chk("rst_err_neg", 32'({i1.rsp_err, i1.rsp_neg}), 0);
    chk("rst_sel", 32'(sel1()), 0);
    chk("rst_cnt", 32'(cnt1), 0);
    rst = 1'b0; rst3 = 1'b0;
    // add 3+3
    req1(2'b00, 2'd3, 2'd3);
    nxt();
    chk("add_sel", 32'(sel1()), 32'b1000);
    chk("add_ops", 32'({i1.calc_op1, i1.calc_op2}), 32'hF);
    chk("add_busy", 32'({i1.req_ready, i1.rsp_valid}), 0);
    i1.req_valid = 1'b0;
    nxt();
    chk("add_rv", 32'(i1.rsp_valid), 1);
    chk("add_sel_off", 32'(sel1()), 0);
    chk("add_data", 32'(i1.rsp_data), 6);
    chk("add_err_neg", 32'({i1.rsp_err, i1.rsp_neg}), 0);
    i1.rsp_ready = 1'b1;
    nxt();
    chk("add_cnt", 32'(cnt1), 1);
    chk("add_idle", 32'({i1.req_ready, i1.rsp_valid}), 32'b10);
    i1.rsp_ready = 1'b0;
    // sub 1-2 -> 0111, negative
    req1(2'b01, 2'd1, 2'd2);
    nxt();
    chk("sub_sel", 32'(sel1()), 32'b0010);
    i1.req_valid = 1'b0;
    nxt();
    chk("sub_data", 32'(i1.rsp_data), 7);
    chk("sub_neg", 32'(i1.rsp_neg), 1);
    chk("sub_err", 32'(i1.rsp_err), 0);
    i1.rsp_ready = 1'b1;
    nxt();
    chk("sub_cnt", 32'(cnt1), 2);
    // mult 3x3 then div 3/2 back-to-back
    req1(2'b10, 2'd3, 2'd3);
    nxt();
    chk("mul_sel", 32'(sel1()), 32'b0100);
    req1(2'b11, 2'd3, 2'd2);
    nxt();
    chk("mul_data", 32'(i1.rsp_data), 9);
    chk("mul_rdy", 32'({i1.req_ready, i1.rsp_valid}), 32'b01);
    nxt();
    chk("b2b_idle", 32'({i1.req_ready, i1.rsp_valid}), 32'b10);
    chk("b2b_sel", 32'(sel1()), 0);
    chk("b2b_cnt", 32'(cnt1), 3);
    nxt();
    chk("div_sel", 32'(sel1()), 32'b0001);
    chk("div_ops", 32'({i1.calc_op1, i1.calc_op2}), 32'b1110);
    i1.req_valid = 1'b0;
    nxt();
    chk("div_data", 32'(i1.rsp_data), 32'b0101);
    nxt();
    chk("div_cnt", 32'(cnt1), 4);
    i1.rsp_ready = 1'b0;
    // divide by zero, then hold the response
    req1(2'b11, 2'd2, 2'd0);
    nxt();
    chk("dz_rv", 32'(i1.rsp_valid), 1);
    chk("dz_sel", 32'(sel1()), 0);
    chk("dz_err", 32'(i1.rsp_err), 1);
    chk("dz_data", 32'({i1.rsp_data, i1.rsp_neg}), 0);
    for (int i = 0; i < 5; i++) begin
      i1.req_valid = i[0];
      i1.req_op = 2'b00;
      ovr = 1'b1;
      ovr_val = 4'(i + 3);
      nxt();
      chk("hold_out", 32'({i1.rsp_valid, i1.rsp_err, i1.rsp_neg, i1.rsp_data}), 32'b110_0000);
      chk("hold_rdy", 32'(i1.req_ready), 0);
      chk("hold_cnt", 32'(cnt1), 4);
    end
    ovr = 1'b0;
    i1.req_valid = 1'b0;
    i1.rsp_ready = 1'b1;
    nxt();
    chk("rel_cnt", 32'(cnt1), 5);
    chk("rel_rv", 32'(i1.rsp_valid), 0);
    nxt();
    chk("rel_cnt2", 32'(cnt1), 5);
    // error flag clears on a normal op
    req1(2'b00, 2'd1, 2'd2);
    nxt();
    i1.req_valid = 1'b0;
    nxt();
    chk("clr_err", 32'({i1.rsp_err, i1.rsp_data}), 32'b0_0011);
    // SETTLE_CYCLES=3: reset in the middle of DRIVE
    req3(2'b00, 2'd2, 2'd1);
    nxt();
    chk("s3_sel_c1", 32'(sel3()), 32'b1000);
    i3.req_valid = 1'b0;
    nxt();
    chk("s3_sel_c2", 32'(sel3()), 32'b1000);
    rst3 = 1'b1;
    nxt();
    rst3 = 1'b0;
    chk("mrst_sel", 32'({sel3(), i3.calc_op1, i3.calc_op2}), 0);
    chk("mrst_rdy", 32'({i3.req_ready, i3.rsp_valid}), 32'b10);
    chk("mrst_rsp", 32'({i3.rsp_data, i3.rsp_err, i3.rsp_neg}), 0);
    chk("mrst_cnt", 32'(cnt3), 0);
    nxt();
    chk("mrst_norsp", 32'(i3.rsp_valid), 0);
    // SETTLE_CYCLES=3 latency
    req3(2'b00, 2'd2, 2'd1);
    nxt();
    i3.req_valid = 1'b0;
    nxt();
    nxt();
    chk("s3_sel_c3", 32'(sel3()), 32'b1000);
    chk("s3_rv_c3", 32'(i3.rsp_valid), 0);
    nxt();
    chk("s3_rv_c4", 32'(i3.rsp_valid), 1);
    chk("s3_data", 32'(i3.rsp_data), 3);
    i3.rsp_ready = 1'b1;
    nxt();
    chk("s3_cnt", 32'(cnt3), 1);
    // fill counter to 255 with divide-by-zero ops, then wrap
    req3(2'b11, 2'd1, 2'd0);
    repeat (2 * 254) nxt();
    i3.req_valid = 1'b0;
    chk("cnt_255", 32'(cnt3), 255);
    req3(2'b11, 2'd1, 2'd0);
    nxt();
    i3.req_valid = 1'b0;
    nxt();
    chk("cnt_wrap", 32'(cnt3), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
